// File: rtl/led_fade_pkg.sv
// Shared definitions for the LED breathing fader: FSM encoding and level helpers.
package led_fade_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    function automatic int unsigned max_level(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter with a registered duty comparator.
module led_pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [PWM_BITS-1:0] i_level,
    output logic                o_pwm
);

    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] pwm_cnt;

    // Strict less-than: level 0 never lights, level MAX is dark only at cnt == MAX.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pwm_cnt <= '0;
            o_pwm   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + ONE;
            o_pwm   <= (pwm_cnt < i_level);
        end
    end

endmodule

// File: rtl/led_fade_pwm.sv
// Turns a raw blink level into a breathing LED: level ramps up/down linearly, PWM drives the pin.
module led_fade_pwm
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_led,
    input  logic                i_enable,
    output logic                o_pwm,
    output logic [PWM_BITS-1:0] o_level,
    output logic [1:0]          o_state,
    output logic                o_busy
);

    localparam logic [PWM_BITS-1:0] MAX       = PWM_BITS'(max_level(PWM_BITS));
    localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);
    localparam logic [15:0]         STEP_LAST = 16'(STEP_CYCLES - 1);

    state_t              state;
    logic                led_q;
    logic [PWM_BITS-1:0] level;
    logic [15:0]         presc;
    logic                tick;

    assign tick = (presc == STEP_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            led_q <= 1'b0;
        end else begin
            led_q <= i_led;
        end
    end

    // Direction reversal wins over a coincident tick so the level is kept on the turn.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_OFF;
            level <= '0;
            presc <= '0;
        end else if (!i_enable) begin
            state <= S_OFF;
            level <= '0;
            presc <= '0;
        end else begin
            case (state)
                S_OFF: begin
                    level <= '0;
                    presc <= '0;
                    if (led_q) begin
                        state <= S_UP;
                    end
                end
                S_UP: begin
                    if (!led_q) begin
                        state <= S_DOWN;
                        presc <= '0;
                    end else if (tick) begin
                        presc <= '0;
                        if (level >= MAX - ONE) begin
                            level <= MAX;
                            state <= S_ON;
                        end else begin
                            level <= level + ONE;
                        end
                    end else begin
                        presc <= presc + 16'd1;
                    end
                end
                S_ON: begin
                    level <= MAX;
                    presc <= '0;
                    if (!led_q) begin
                        state <= S_DOWN;
                    end
                end
                S_DOWN: begin
                    if (led_q) begin
                        state <= S_UP;
                        presc <= '0;
                    end else if (tick) begin
                        presc <= '0;
                        if (level <= ONE) begin
                            level <= '0;
                            state <= S_OFF;
                        end else begin
                            level <= level - ONE;
                        end
                    end else begin
                        presc <= presc + 16'd1;
                    end
                end
                default: begin
                    state <= S_OFF;
                    level <= '0;
                    presc <= '0;
                end
            endcase
        end
    end

    led_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_level   (level),
        .o_pwm     (o_pwm)
    );

    assign o_level = level;
    assign o_state = state;
    assign o_busy  = (state == S_UP) || (state == S_DOWN);

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for the LED fader: small 4-bit instance for corner cases, 8-bit instance fed by a blinker counter.
module tb_led_fade_pwm;

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_DOWN = 2'd3;

    logic       clk;
    logic       rst_n;
    logic       led;
    logic       en;
    logic       pwm;
    logic [3:0] level;
    logic [1:0] state;
    logic       busy;

    logic       led2;
    logic       en2;
    logic       pwm2;
    logic [7:0] level2;
    logic [1:0] state2;
    logic       busy2;

    int n_cmp;
    int n_err;

    led_fade_pwm #(
        .PWM_BITS    (4),
        .STEP_CYCLES (2)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_led     (led),
        .i_enable  (en),
        .o_pwm     (pwm),
        .o_level   (level),
        .o_state   (state),
        .o_busy    (busy)
    );

    led_fade_pwm #(
        .PWM_BITS    (8),
        .STEP_CYCLES (4)
    ) dut_big (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_led     (led2),
        .i_enable  (en2),
        .o_pwm     (pwm2),
        .o_level   (level2),
        .o_state   (state2),
        .o_busy    (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       led;
        logic       en;
        int         n;
        logic [3:0] lvl;
        logic [1:0] st;
        logic       bsy;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int highs;
        logic [11:0] blink;
        logic [7:0]  prev;

        n_cmp = 0;
        n_err = 0;
        led   = 1'b0;
        en    = 1'b1;
        led2  = 1'b0;
        en2   = 1'b1;
        rst_n = 1'b0;

        // Each row: apply inputs, advance n edges from the previous row, expect the outputs.
        vecs[0]  = '{1'b1, 1'b1,  1,  4'd0, ST_OFF,  1'b0};
        vecs[1]  = '{1'b1, 1'b1,  1,  4'd0, ST_UP,   1'b1};
        vecs[2]  = '{1'b1, 1'b1,  1,  4'd0, ST_UP,   1'b1};
        vecs[3]  = '{1'b1, 1'b1,  1,  4'd1, ST_UP,   1'b1};
        vecs[4]  = '{1'b1, 1'b1, 12,  4'd7, ST_UP,   1'b1};
        vecs[5]  = '{1'b0, 1'b1,  1,  4'd7, ST_UP,   1'b1};
        vecs[6]  = '{1'b0, 1'b1,  1,  4'd7, ST_DOWN, 1'b1};
        vecs[7]  = '{1'b0, 1'b1,  2,  4'd6, ST_DOWN, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 10,  4'd1, ST_DOWN, 1'b1};
        vecs[9]  = '{1'b0, 1'b1,  2,  4'd0, ST_OFF,  1'b0};
        vecs[10] = '{1'b0, 1'b1,  4,  4'd0, ST_OFF,  1'b0};
        vecs[11] = '{1'b1, 1'b1,  2,  4'd0, ST_UP,   1'b1};
        vecs[12] = '{1'b1, 1'b1, 29, 4'd14, ST_UP,   1'b1};
        vecs[13] = '{1'b1, 1'b1,  1, 4'd15, ST_ON,   1'b0};
        vecs[14] = '{1'b1, 1'b1,  5, 4'd15, ST_ON,   1'b0};

        // Reset state while reset is held
        step(3);
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_state", 32'(state), 32'(ST_OFF));
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Idle with LED low: everything stays dark
        for (int i = 0; i < 100; i++) begin
            step(1);
            check("idle", 32'({pwm, level, state, busy}), 32'd0);
        end

        // Ramp up, reverse at level 7, ramp down to 0, ramp up to MAX
        for (int i = 0; i < 15; i++) begin
            led = vecs[i].led;
            en  = vecs[i].en;
            step(vecs[i].n);
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
        end

        // Full brightness: 15 high cycles out of every 16
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            highs += int'(pwm);
        end
        check("pwm_max_duty", 32'(highs), 32'd15);

        // Enable drop overrides a simultaneous LED toggle
        en  = 1'b0;
        led = 1'b0;
        step(1);
        check("dis_state", 32'(state), 32'(ST_OFF));
        check("dis_level", 32'(level), 32'd0);
        en  = 1'b1;
        led = 1'b1;
        step(1);
        check("dis_pwm", 32'(pwm), 32'd0);
        check("dis_state2", 32'(state), 32'(ST_OFF));
        step(2);
        check("reen_state", 32'(state), 32'(ST_UP));
        check("reen_level", 32'(level), 32'd0);
        step(2);
        check("reen_level1", 32'(level), 32'd1);
        step(15);
        check("mid_level9", 32'(level), 32'd9);
        check("mid_state", 32'(state), 32'(ST_UP));

        // Asynchronous reset mid-ramp clears outputs before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pwm", 32'(pwm), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_state", 32'(state), 32'(ST_OFF));
        check("arst_busy", 32'(busy), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("post_rst_state", 32'(state), 32'(ST_OFF));
        step(1);
        check("post_rst_up", 32'(state), 32'(ST_UP));
        check("post_rst_level", 32'(level), 32'd0);

        // Integration: 8-bit fader driven by a 12-bit blinker MSB
        led   = 1'b0;
        rst_n = 1'b0;
        blink = '0;
        led2  = 1'b0;
        step(1);
        rst_n = 1'b1;
        prev  = 8'd0;
        for (int k = 1; k <= 12288; k++) begin
            step(1);
            if (state2 == ST_UP || state2 == ST_ON) begin
                check("sweep_up", 32'(level2 >= prev && level2 - prev <= 8'd1), 32'd1);
            end else begin
                check("sweep_down", 32'(level2 <= prev && prev - level2 <= 8'd1), 32'd1);
            end
            if (k % 2048 == 0) begin
                if ((k / 2048) % 2 == 0) begin
                    check("half_on_level", 32'(level2), 32'd255);
                    check("half_on_state", 32'(state2), 32'(ST_ON));
                end else begin
                    check("half_off_level", 32'(level2), 32'd0);
                    check("half_off_state", 32'(state2), 32'(ST_OFF));
                end
            end
            prev  = level2;
            blink = blink + 12'd1;
            led2  = blink[11];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Downstream consumer of the blinky counter's LED output.
- Takes the raw square-wave blink level and drives the physical LED with a PWM signal whose duty cycle ramps linearly up and down, giving a "breathing" fade instead of a hard toggle.
- Single clock domain, shared with the blinker; Verilator-simulable; no vendor primitives.

Parameters:
- PWM_BITS, 8, duty resolution; PWM period is 2^PWM_BITS cycles; max level is 2^PWM_BITS-1.
- STEP_CYCLES, 4, clock cycles per one-level brightness step while ramping; legal range is 1 to 2^16-1.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- i_led  in  1  raw blink level from the upstream blinker; synchronous to i_clk.
- i_enable  in  1  1 = fading active; 0 = LED forced dark.
- o_pwm  out  1  PWM drive to the LED pin, registered.
- o_level  out  PWM_BITS  current brightness level, registered.
- o_state  out  2  FSM state, using the package encoding.
- o_busy  out  1  1 while in S_UP or S_DOWN.

Behaviour:
- Reset (i_reset_n=0, asynchronous):
  - all outputs are 0; state is S_OFF; PWM counter, prescaler and led_q are 0.
  - Deassertion takes effect on the next rising edge.
  - A reset in mid-ramp discards level immediately.
- Input stage: led_q <= i_led, one register. The FSM acts only on led_q.
- FSM states: S_OFF=0, S_UP=1, S_ON=2, S_DOWN=3.
  - S_OFF: level=0. If led_q=1 and i_enable=1, go to S_UP and clear the prescaler.
  - S_UP:
    - On each step tick, level+1.
    - On the tick where level = MAX-1, level becomes MAX and the state goes to S_ON.
    - If led_q=0, go to S_DOWN this edge with level unchanged and the prescaler cleared.
  - S_ON: level=MAX. If led_q=0, go to S_DOWN and clear the prescaler.
  - S_DOWN:
    - On each tick, level-1.
    - On the tick where level = 1, level becomes 0 and the state goes to S_OFF.
    - If led_q=1, go to S_UP with level unchanged and the prescaler cleared.
  - i_enable=0 overrides everything: the next edge gives state=S_OFF and level=0, then o_pwm=0 one edge later.
  - Enable has priority over a simultaneous led_q change.
- Step prescaler:
  - Counts 0..STEP_CYCLES-1 only in S_UP or S_DOWN and wraps to 0.
  - A tick is the edge at which the prescaler equals STEP_CYCLES-1.
  - The first step occurs STEP_CYCLES edges after entering a ramp state.
  - A full ramp takes MAX*STEP_CYCLES cycles.
- Level arithmetic: unsigned, PWM_BITS wide, saturating by construction. Level never wraps: no increment at MAX, no decrement at 0.
- PWM generation:
  - pwm_cnt is free-running PWM_BITS wide, incrementing every cycle and wrapping MAX->0. It is independent of the FSM.
  - o_pwm <= (pwm_cnt < level), so it lags level by 1 cycle.
  - level=0 gives o_pwm constantly 0.
  - level=MAX gives o_pwm high for MAX of every 2^PWM_BITS cycles, low only when pwm_cnt=MAX.
- Latency: a change on i_led reaches led_q after 1 edge, o_state after 2 edges, and the first o_level change after 2+STEP_CYCLES edges.
- o_busy is decoded combinationally from the state register; there is no extra latency.

Decomposition:
- Package led_fade_pkg holds:
  - the state encoding typedef (2-bit enum S_OFF/S_UP/S_ON/S_DOWN);
  - function max_level(PWM_BITS).
- One sub-module, led_pwm_gen: free-running pwm_cnt plus the registered comparator.
  - Parameter PWM_BITS.
  - Ports: i_clk, i_reset_n, i_level, o_pwm.
- The FSM, prescaler and level register stay in led_fade_pwm.

Test Plan (PWM_BITS=4, STEP_CYCLES=2, MAX=15 unless noted):
- Reset then idle, i_led=0, i_enable=1, run 100 cycles -> o_pwm=0, o_level=0, o_state=S_OFF and o_busy=0 throughout.
- Rise i_led at edge 0 and hold -> o_state=S_UP at edge 2; o_level=1 at edge 4; o_level=15 and o_state=S_ON at edge 32; o_busy=0 from edge 32. Over the next 16 cycles o_pwm shows exactly 15 highs.
- In S_UP at level 7, drop i_led -> S_DOWN 2 edges later with o_level still 7; o_level=6 two edges after that; the ramp reaches 0 and S_OFF with no wrap to 15.
- In S_ON, hold i_enable=0 for 1 cycle while toggling i_led -> next edge o_state=S_OFF and o_level=0; one edge later o_pwm=0. Re-enabling with i_led=1 restarts S_UP from 0.
- Assert i_reset_n=0 asynchronously mid-ramp at level 9 -> all outputs are 0 before the next clock edge. After release the FSM resumes from S_OFF.
- Integration with PWM_BITS=8, STEP_CYCLES=4, driven by the upstream blinker's 12-bit counter MSB (half-period 2048) -> o_level reaches 255 (1020 cycles) and then holds S_ON in every half-period; the duty sweep is monotonic on both edges.
